// File: rtl/matmul10_ctrl_mac_if.sv
// Signal bundle between the matmul sequencer/MAC core and the enclosing top level.
// The top level acts as master; the core is the slave.
interface matmul10_ctrl_mac_if #(
    parameter int N  = 10,
    parameter int DW = 8,
    parameter int RW = 16
);
    // Strobe protocol: load, start_mac and w_en are single-cycle level strobes.
    // The top level acts on each one at the rising edge where it is high.
    // There is no back-pressure; mm_done is a level qualifier, not a handshake.
    logic            start;
    logic            mm_done;
    logic [N*DW-1:0] a_vec;
    logic [N*DW-1:0] b_vec;
    logic            load;
    logic            start_mac;
    logic            w_en;
    logic            done;
    logic [RW-1:0]   sop;
    logic [1:0]      state_dbg;

    modport master (
        output start, mm_done, a_vec, b_vec,
        input  load, start_mac, w_en, done, sop, state_dbg
    );

    modport slave (
        input  start, mm_done, a_vec, b_vec,
        output load, start_mac, w_en, done, sop, state_dbg
    );
endinterface

// File: rtl/matmul10_ctrl_mac.sv
// Sequencing FSM plus a combinational 10-term signed dot product for a 10x10 int8 matrix multiplier.
// The core drives load/operand-advance/write strobes; the top level owns the counters and memories.
module matmul10_ctrl_mac #(
    parameter int N  = 10,
    parameter int DW = 8,
    parameter int RW = 16
) (
    input  logic                clk,
    input  logic                rst,
    matmul10_ctrl_mac_if.slave  bus
);

    localparam int PW = 2 * DW;
    localparam int SW = 20;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        FIN     = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   primed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            primed <= 1'b0;
        end else begin
            state  <= state_nxt;
            // Write lags the operand latch by one cycle, so w_en only opens after the first COMPUTE cycle.
            primed <= (state == COMPUTE);
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.load      = 1'b0;
        bus.start_mac = 1'b0;
        bus.w_en      = 1'b0;
        bus.done      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = LOAD;
            end
            LOAD: begin
                bus.load  = 1'b1;
                state_nxt = COMPUTE;
            end
            COMPUTE: begin
                bus.start_mac = !bus.mm_done;
                bus.w_en      = primed;
                if (bus.mm_done) state_nxt = FIN;
            end
            FIN: begin
                bus.done = 1'b1;
                if (!bus.start) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.state_dbg = state;

    logic signed [SW-1:0] acc;

    always_comb begin
        logic signed [PW-1:0] a_ext;
        logic signed [PW-1:0] b_ext;
        logic signed [PW-1:0] prod;
        acc   = '0;
        a_ext = '0;
        b_ext = '0;
        prod  = '0;
        for (int k = 0; k < N; k++) begin
            a_ext = {{DW{bus.a_vec[k*DW+DW-1]}}, bus.a_vec[k*DW +: DW]};
            b_ext = {{DW{bus.b_vec[k*DW+DW-1]}}, bus.b_vec[k*DW +: DW]};
            prod  = a_ext * b_ext;
            acc   = acc + {{(SW-PW){prod[PW-1]}}, prod};
        end
    end

    // Result wraps modulo 2^16; no saturation.
    assign bus.sop = acc[RW-1:0];

endmodule

// File: tb/tb_matmul10_ctrl_mac.sv
// Bench for matmul10_ctrl_mac: table-driven and random MAC vectors against an arithmetic model,
// plus strobe-sequence runs against a per-cycle expected trace (full run, early mm_done, abort).
module tb_matmul10_ctrl_mac;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matmul10_ctrl_mac_if bus ();

    matmul10_ctrl_mac u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- scoreboard state ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] exp_q[$];
    int         mac_cnt;

    typedef struct {
        string       name;
        logic [79:0] a;
        logic [79:0] b;
        logic [15:0] exp;
    } mac_vec_t;

    mac_vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] ctrl_now();
        return {bus.load, bus.start_mac, bus.w_en, bus.done};
    endfunction

    function automatic logic [79:0] splat(input logic [7:0] v);
        return {10{v}};
    endfunction

    // Reference dot product: plain integer arithmetic, keep the low 16 bits.
    function automatic logic [15:0] mac_model(input logic [79:0] a, input logic [79:0] b);
        int  s;
        byte ak;
        byte bk;
        s = 0;
        for (int k = 0; k < 10; k++) begin
            ak = a[8*k +: 8];
            bk = b[8*k +: 8];
            s  = s + int'(ak) * int'(bk);
        end
        return s[15:0];
    endfunction

    // Expected {load,start_mac,w_en,done} at cycle t after the start edge, for m operand advances.
    function automatic logic [3:0] exp_ctrl(input int t, input int m);
        return {t == 0, (t >= 1) && (t <= m), (t >= 2) && (t <= m + 1), t >= m + 2};
    endfunction

    // ---------------- driver tasks ----------------
    // Runs one start..FIN..IDLE sequence; the bench plays the top-level counter that raises mm_done
    // after m start_mac cycles. abort_at > 0 asserts rst mid-cycle at that cycle instead.
    task automatic run_seq(input int m, input int fin_hold, input int abort_at);
        logic [3:0] e;
        int         last_t;
        last_t = m + 2 + fin_hold;
        exp_q.delete();
        for (int t = 0; t <= last_t; t++) exp_q.push_back(exp_ctrl(t, m));
        mac_cnt     = 0;
        bus.mm_done = (m == 0);
        bus.start   = 1'b1;
        for (int t = 0; t <= last_t; t++) begin
            @(posedge clk);
            #1;
            bus.mm_done = (mac_cnt >= m);
            #1;
            e = exp_q.pop_front();
            check($sformatf("ctrl m=%0d t=%0d", m, t), 32'(ctrl_now()), 32'(e));
            mac_cnt += int'(bus.start_mac);
            if (abort_at > 0 && t == abort_at) begin
                rst = 1'b1;
                #1;
                check($sformatf("abort ctrl t=%0d", t), 32'(ctrl_now()), 32'h0);
                @(negedge clk);
                @(negedge clk);
                check("ctrl held in reset", 32'(ctrl_now()), 32'h0);
                rst         = 1'b0;
                bus.start   = 1'b0;
                bus.mm_done = 1'b0;
                return;
            end
        end
        bus.start = 1'b0;
        @(posedge clk);
        #2;
        check($sformatf("idle after drop m=%0d", m), 32'(ctrl_now()), 32'h0);
    endtask

    // ---------------- main test ----------------
    initial begin
        logic [79:0] va;
        logic [79:0] vb;

        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.mm_done = 1'b0;
        bus.a_vec   = '0;
        bus.b_vec   = '0;
        #2;
        check("reset ctrl", 32'(ctrl_now()), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #2;
            check($sformatf("idle start=0 cyc %0d", i), 32'(ctrl_now()), 32'h0);
        end

        // MAC vector table with hand-derived expectations
        for (int k = 0; k < 10; k++) begin
            va[8*k +: 8] = 8'(k);
        end
        tbl.push_back('{"ramp k*k", va, va, 16'd285});
        tbl.push_back('{"ones x nines", splat(8'd1), splat(8'd9), 16'd90});
        tbl.push_back('{"nines x nines", splat(8'd9), splat(8'd9), 16'd810});
        tbl.push_back('{"min x min wrap", splat(8'h80), splat(8'h80), 16'h8000});
        tbl.push_back('{"max x min wrap", splat(8'h7f), splat(8'h80), 16'h8500});
        va = '0;
        vb = '0;
        va[7:0] = 8'hfb;
        vb[7:0] = 8'd7;
        tbl.push_back('{"lane0 -5*7", va, vb, 16'hffdd});
        foreach (tbl[i]) begin
            bus.a_vec = tbl[i].a;
            bus.b_vec = tbl[i].b;
            #1;
            check(tbl[i].name, 32'(bus.sop), 32'(tbl[i].exp));
        end

        // random MAC vectors against the model
        for (int i = 0; i < 100; i++) begin
            for (int k = 0; k < 10; k++) begin
                va[8*k +: 8] = 8'($urandom_range(0, 255));
                vb[8*k +: 8] = 8'($urandom_range(0, 255));
            end
            bus.a_vec = va;
            bus.b_vec = vb;
            #1;
            check($sformatf("rand mac %0d", i), 32'(bus.sop), 32'(mac_model(va, vb)));
        end

        @(negedge clk);
        run_seq(100, 3, 0);
        run_seq(0, 2, 0);
        run_seq(100, 0, 50);
        run_seq(100, 1, 0);
        for (int r = 0; r < 4; r++) begin
            run_seq(int'($urandom_range(1, 20)), int'($urandom_range(0, 3)), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matmul10_ctrl_mac.md
Name: matmul10_ctrl_mac

Overview:
- Control-plus-datapath core for a 10x10 signed 8-bit matrix multiplier.
- Contains a sequencing FSM and a purely combinational 10-term signed multiply-accumulate (dot product).
- The enclosing top level owns the matrix memories, the row/column address counters and the result memory. It loads A/B on `load`, advances counters and latches operands on `start_mac`, and writes `sop` into the result memory on `w_en`. It reports completion of the last element via `mm_done`.

Parameters:
- N, 10, number of dot-product terms (fixed at 10; other values need not be supported).
- DW, 8, operand width (signed).
- RW, 16, result width (signed).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  start request; level-sampled.
- mm_done  input  1  from top-level counters; high once the last (row 9, col 9) operands have been latched.
- a_vec  input  80  row operands, 10 signed 8-bit; a_k = a_vec[8k+7:8k].
- b_vec  input  80  column operands, 10 signed 8-bit; b_k = b_vec[8k+7:8k].
- load  output  1  matrix load strobe.
- start_mac  output  1  advance counters and latch next operands.
- w_en  output  1  write `sop` to the result memory this cycle.
- done  output  1  multiplication complete.
- sop  output  16  signed sum of a_k*b_k, k=0..9.

Behaviour:
- Reset: asynchronous, active-high; rst=1 forces state IDLE and clears the w_en-priming flag. load, start_mac, w_en and done are all 0. Reset mid-operation aborts immediately, with no further writes.
- FSM states: IDLE, LOAD, COMPUTE, FIN. Outputs are decoded from state (plus the priming flag and mm_done as noted).
- IDLE: all outputs 0. If start=1 at a clock edge, go to LOAD.
- LOAD: exactly one cycle; load=1. Then go to COMPUTE and clear the priming flag.
- COMPUTE: start_mac = !mm_done.
  - w_en = priming flag. The flag is set at the end of the first COMPUTE cycle, so w_en is 0 in the first COMPUTE cycle and 1 in every later one. This gives a 1-cycle lag between operand latch and write.
  - When mm_done=1 in COMPUTE: w_en=1 (final write), start_mac=0, and the next state is FIN.
  - Net effect with a 100-element top level: 100 start_mac cycles, then 100 w_en cycles offset by one. COMPUTE lasts 101 cycles.
- FIN: done=1; load, start_mac and w_en are 0. Stay in FIN while start=1; return to IDLE when start=0.
- start is ignored in LOAD and COMPUTE. mm_done is ignored outside COMPUTE.
- MAC datapath:
  - Purely combinational, independent of clk, rst and FSM state; sop is valid in the same cycle as a_vec/b_vec.
  - Each product is a full signed 8x8 -> 16-bit product.
  - Products are summed at ≥20-bit signed width.
  - sop = low 16 bits of the sum, two's-complement wrap with no saturation.
  - Unsigned test matrices 0..9 stay in range (maximum 10*81 = 810).

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> load/start_mac/w_en/done = 0 immediately. Release, hold start=0 for 5 cycles -> all outputs remain 0.
- Full run: pulse start (held high). Bench models mm_done as high after 100 start_mac cycles -> load high exactly 1 cycle, then start_mac high 100 consecutive cycles, w_en high 100 consecutive cycles starting one cycle after the first start_mac, then done=1 held. Drop start -> IDLE and done=0 on the next edge.
- MAC ramp: a_k = b_k = k (k=0..9) -> sop = 285. All a_k = 1, b_k = 9 -> sop = 90.
- MAC signed/wrap: all a=b=-128 -> sop = 16'h8000 (-32768). All a=127, b=-128 -> sop = 16'h8500 (-31488). a_0=-5, b_0=7, others 0 -> sop = -35.
- Abort: assert rst on the 50th COMPUTE cycle -> w_en/start_mac drop immediately. After release, a new start produces a complete fresh sequence (load again, w_en low in the first COMPUTE cycle).
- mm_done already high in the first COMPUTE cycle -> start_mac=0, w_en=0 that cycle, next state FIN with done=1.
